// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

  localparam int unsigned MULT_BITS_MIN = 2;
  localparam int unsigned MULT_BITS_MAX = 32;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mult_state_e;

  // Step counter width; counts 0..bits-1.
  function automatic int unsigned cnt_width(input int unsigned bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: conditionally add/subtract mcand, then shift {acc, mplier} right.
// Subtraction only exists when MULT_SIGNED_EN is defined.
module mult_step #(
  parameter int unsigned BITS = 8
) (
  input  logic [BITS:0]   acc_i,
  input  logic [BITS-1:0] mplier_i,
  input  logic [BITS:0]   mcand_i,
  input  logic            sub_i,
  input  logic            signed_i,
  output logic [BITS:0]   acc_o,
  output logic [BITS-1:0] mplier_o
);

  localparam int unsigned W = BITS + 2;

  logic [W-1:0] acc_ext;
  logic [W-1:0] addend;
  logic [W-1:0] sum;

  // Sign extension in signed mode makes the right shift arithmetic; in unsigned mode the extra
  // top bit captures the carry-out.
  assign acc_ext = {signed_i & acc_i[BITS], acc_i};
  assign addend  = mplier_i[0] ? {signed_i & mcand_i[BITS], mcand_i} : '0;

`ifdef MULT_SIGNED_EN
  assign sum = sub_i ? (acc_ext - addend) : (acc_ext + addend);
`else
  logic unused_sub;
  assign unused_sub = sub_i;
  assign sum = acc_ext + addend;
`endif

  assign acc_o    = sum[W-1:1];
  assign mplier_o = {sum[0], mplier_i[BITS-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with valid/ready handshakes, BITS cycles per product.
// Define MULT_SIGNED_EN to add the signed_mode port and two's-complement support.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITS-1:0]   A,
  input  logic [BITS-1:0]   B,
`ifdef MULT_SIGNED_EN
  input  logic              signed_mode,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*BITS-1:0] out,
  output logic              busy
);

  localparam int unsigned CntW = cnt_width(BITS);

  if (BITS < MULT_BITS_MIN || BITS > MULT_BITS_MAX) begin : g_bits_range
    $error("seq_multiplier: BITS out of range 2..32");
  end

  mult_state_e state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [BITS:0]     acc_q, acc_d;
  logic [BITS-1:0]   mplier_q, mplier_d;
  logic [BITS:0]     mcand_q, mcand_d;
  logic [2*BITS-1:0] out_q, out_d;

  logic            accept;
  logic            last_step;
  logic            mode_in;
  logic [BITS:0]   step_acc;
  logic [BITS-1:0] step_mplier;

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StBusy);
  assign out_valid = (state_q == StDone);
  assign out       = out_q;

  assign accept    = in_valid && in_ready;
  assign last_step = (count_q == CntW'(BITS - 1));

`ifdef MULT_SIGNED_EN
  logic signed_q;
  assign mode_in = signed_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      signed_q <= 1'b0;
    end else if (accept) begin
      signed_q <= signed_mode;
    end
  end
`else
  logic signed_q;
  assign mode_in  = 1'b0;
  assign signed_q = 1'b0;
`endif

  // The MSB of a signed multiplier carries weight -2^(BITS-1), so the last step subtracts.
  mult_step #(
    .BITS (BITS)
  ) u_step (
    .acc_i    (acc_q),
    .mplier_i (mplier_q),
    .mcand_i  (mcand_q),
    .sub_i    (signed_q && last_step),
    .signed_i (signed_q),
    .acc_o    (step_acc),
    .mplier_o (step_mplier)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    out_d    = out_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d  = StBusy;
          mcand_d  = {mode_in & A[BITS-1], A};
          mplier_d = B;
          acc_d    = '0;
          count_d  = '0;
        end
      end
      StBusy: begin
        acc_d    = step_acc;
        mplier_d = step_mplier;
        count_d  = count_q + CntW'(1);
        if (last_step) begin
          state_d = StDone;
          out_d   = {step_acc[BITS-1:0], step_mplier};
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      out_q    <= out_d;
    end
  end

endmodule
